// File: rtl/poly_raster.sv
// Per-pixel triangle rasterizer: shadows frame geometry, then resolves each streamed
// pixel against all enabled triangles through a 3-stage edge-function pipeline.
module poly_raster #(
    parameter int WCOLOR = 6,
    parameter int WPX    = 10,
    parameter int WPY    = 9,
    parameter int N_POLY = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [WPX-1:0]           pix_x,
    input  logic [WPY-1:0]           pix_y,
    input  logic [WCOLOR-1:0]        bg_color_in,
    input  logic [WCOLOR*N_POLY-1:0] poly_color_in,
    input  logic [WPX*N_POLY-1:0]    v0_x_in,
    input  logic [WPX*N_POLY-1:0]    v1_x_in,
    input  logic [WPX*N_POLY-1:0]    v2_x_in,
    input  logic [WPY*N_POLY-1:0]    v0_y_in,
    input  logic [WPY*N_POLY-1:0]    v1_y_in,
    input  logic [WPY*N_POLY-1:0]    v2_y_in,
    input  logic [N_POLY-1:0]        poly_enable_in,
    output logic                     busy,
    output logic                     color_valid,
    output logic [WCOLOR-1:0]        color_out,
    output logic [N_POLY-1:0]        poly_hit
);

    localparam int WDX = WPX + 1;
    localparam int WDY = WPY + 1;
    localparam int WE  = WPX + WPY + 3;

    function automatic logic signed [WDX-1:0] diff_x(input logic [WPX-1:0] a,
                                                     input logic [WPX-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [WDY-1:0] diff_y(input logic [WPY-1:0] a,
                                                     input logic [WPY-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    function automatic logic signed [WE-1:0] ext_x(input logic signed [WDX-1:0] v);
        return {{(WE-WDX){v[WDX-1]}}, v};
    endfunction

    function automatic logic signed [WE-1:0] ext_y(input logic signed [WDY-1:0] v);
        return {{(WE-WDY){v[WDY-1]}}, v};
    endfunction

    // Full-width result: the products never exceed WE bits, so nothing is truncated.
    function automatic logic signed [WE-1:0] edge_fn(input logic signed [WDX-1:0] ex,
                                                     input logic signed [WDY-1:0] ey,
                                                     input logic signed [WDX-1:0] dx,
                                                     input logic signed [WDY-1:0] dy);
        return ext_x(ex) * ext_y(dy) - ext_y(ey) * ext_x(dx);
    endfunction

    logic [WCOLOR-1:0]              bg_q;
    logic [N_POLY-1:0][WCOLOR-1:0]  pcol_q;
    logic [N_POLY-1:0][WPX-1:0]     v0x_q, v1x_q, v2x_q;
    logic [N_POLY-1:0][WPY-1:0]     v0y_q, v1y_q, v2y_q;
    logic [N_POLY-1:0]              en_q;

    logic signed [WDX-1:0] ex_q [N_POLY][3];
    logic signed [WDY-1:0] ey_q [N_POLY][3];
    logic signed [WDX-1:0] ex_d [N_POLY][3];
    logic signed [WDY-1:0] ey_d [N_POLY][3];
    logic [N_POLY-1:0]     deg_q, deg_d;

    logic                  busy_q;
    logic                  vld_p1_q, vld_p2_q, color_valid_q;
    logic                  accept;
    logic                  adv_p2;

    logic signed [WDX-1:0] dx_p1_q [N_POLY][3];
    logic signed [WDY-1:0] dy_p1_q [N_POLY][3];
    logic signed [WE-1:0]  e_p2_q  [N_POLY][3];

    logic [N_POLY-1:0]     hit_d, hit_q;
    logic [WCOLOR-1:0]     color_d, color_q;

    assign accept = pix_valid && !frame_start && !busy_q;
    assign adv_p2 = vld_p2_q && !frame_start;

    // Precompute: edge vectors and twice-area zero test from the shadowed vertices.
    always_comb begin
        ex_d  = '{default: '0};
        ey_d  = '{default: '0};
        deg_d = '0;
        for (int i = 0; i < N_POLY; i++) begin
            ex_d[i][0] = diff_x(v1x_q[i], v0x_q[i]);
            ey_d[i][0] = diff_y(v1y_q[i], v0y_q[i]);
            ex_d[i][1] = diff_x(v2x_q[i], v1x_q[i]);
            ey_d[i][1] = diff_y(v2y_q[i], v1y_q[i]);
            ex_d[i][2] = diff_x(v0x_q[i], v2x_q[i]);
            ey_d[i][2] = diff_y(v0y_q[i], v2y_q[i]);
            deg_d[i]   = (edge_fn(ex_d[i][0], ey_d[i][0],
                                  diff_x(v2x_q[i], v0x_q[i]),
                                  diff_y(v2y_q[i], v0y_q[i])) == '0);
        end
    end

    // Stage 3 resolve: winding-independent inside test, lowest index wins.
    always_comb begin
        hit_d   = '0;
        color_d = bg_q;
        for (int i = 0; i < N_POLY; i++) begin
            hit_d[i] = en_q[i] && !deg_q[i] &&
                       ((!e_p2_q[i][0][WE-1] && !e_p2_q[i][1][WE-1] && !e_p2_q[i][2][WE-1]) ||
                        ((e_p2_q[i][0][WE-1] || e_p2_q[i][0] == '0) &&
                         (e_p2_q[i][1][WE-1] || e_p2_q[i][1] == '0) &&
                         (e_p2_q[i][2][WE-1] || e_p2_q[i][2] == '0)));
        end
        for (int i = N_POLY - 1; i >= 0; i--) begin
            if (hit_d[i]) color_d = pcol_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bg_q          <= '0;
            pcol_q        <= '0;
            v0x_q         <= '0;
            v1x_q         <= '0;
            v2x_q         <= '0;
            v0y_q         <= '0;
            v1y_q         <= '0;
            v2y_q         <= '0;
            en_q          <= '0;
            deg_q         <= '1;
            busy_q        <= 1'b0;
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            color_valid_q <= 1'b0;
            color_q       <= '0;
            hit_q         <= '0;
            for (int i = 0; i < N_POLY; i++) begin
                for (int k = 0; k < 3; k++) begin
                    ex_q[i][k] <= '0;
                    ey_q[i][k] <= '0;
                end
            end
        end else begin
            busy_q        <= frame_start;
            vld_p1_q      <= accept;
            vld_p2_q      <= vld_p1_q && !frame_start;
            color_valid_q <= adv_p2;
            if (adv_p2) begin
                color_q <= color_d;
                hit_q   <= hit_d;
            end
            if (frame_start) begin
                bg_q   <= bg_color_in;
                pcol_q <= poly_color_in;
                v0x_q  <= v0_x_in;
                v1x_q  <= v1_x_in;
                v2x_q  <= v2_x_in;
                v0y_q  <= v0_y_in;
                v1y_q  <= v1_y_in;
                v2y_q  <= v2_y_in;
                en_q   <= poly_enable_in;
            end
            if (busy_q) begin
                ex_q  <= ex_d;
                ey_q  <= ey_d;
                deg_q <= deg_d;
            end
        end
    end

    // Stage 1 -> stage 2 datapath: offsets then edge functions; gated only by the valids.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_POLY; i++) begin
            dx_p1_q[i][0] <= diff_x(pix_x, v0x_q[i]);
            dy_p1_q[i][0] <= diff_y(pix_y, v0y_q[i]);
            dx_p1_q[i][1] <= diff_x(pix_x, v1x_q[i]);
            dy_p1_q[i][1] <= diff_y(pix_y, v1y_q[i]);
            dx_p1_q[i][2] <= diff_x(pix_x, v2x_q[i]);
            dy_p1_q[i][2] <= diff_y(pix_y, v2y_q[i]);
            for (int k = 0; k < 3; k++) begin
                e_p2_q[i][k] <= edge_fn(ex_q[i][k], ey_q[i][k], dx_p1_q[i][k], dy_p1_q[i][k]);
            end
        end
    end

    assign busy        = busy_q;
    assign color_valid = color_valid_q;
    assign color_out   = color_q;
    assign poly_hit    = hit_q;

endmodule

// File: tb/tb_poly_raster.sv
// Directed self-checking bench for poly_raster with hand-computed expected colours.
module tb_poly_raster;

    localparam int WCOLOR = 6;
    localparam int WPX    = 10;
    localparam int WPY    = 9;
    localparam int N_POLY = 4;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     frame_start;
    logic                     pix_valid;
    logic [WPX-1:0]           pix_x;
    logic [WPY-1:0]           pix_y;
    logic [WCOLOR-1:0]        bg_color_in;
    logic [WCOLOR*N_POLY-1:0] poly_color_in;
    logic [WPX*N_POLY-1:0]    v0_x_in, v1_x_in, v2_x_in;
    logic [WPY*N_POLY-1:0]    v0_y_in, v1_y_in, v2_y_in;
    logic [N_POLY-1:0]        poly_enable_in;
    logic                     busy;
    logic                     color_valid;
    logic [WCOLOR-1:0]        color_out;
    logic [N_POLY-1:0]        poly_hit;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    poly_raster #(
        .WCOLOR(WCOLOR), .WPX(WPX), .WPY(WPY), .N_POLY(N_POLY)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .bg_color_in(bg_color_in), .poly_color_in(poly_color_in),
        .v0_x_in(v0_x_in), .v1_x_in(v1_x_in), .v2_x_in(v2_x_in),
        .v0_y_in(v0_y_in), .v1_y_in(v1_y_in), .v2_y_in(v2_y_in),
        .poly_enable_in(poly_enable_in),
        .busy(busy), .color_valid(color_valid),
        .color_out(color_out), .poly_hit(poly_hit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_poly(input int i,
                            input logic [WPX-1:0] x0, input logic [WPY-1:0] y0,
                            input logic [WPX-1:0] x1, input logic [WPY-1:0] y1,
                            input logic [WPX-1:0] x2, input logic [WPY-1:0] y2,
                            input logic [WCOLOR-1:0] col);
        v0_x_in[i*WPX +: WPX] = x0;
        v0_y_in[i*WPY +: WPY] = y0;
        v1_x_in[i*WPX +: WPX] = x1;
        v1_y_in[i*WPY +: WPY] = y1;
        v2_x_in[i*WPX +: WPX] = x2;
        v2_y_in[i*WPY +: WPY] = y2;
        poly_color_in[i*WCOLOR +: WCOLOR] = col;
    endtask

    // Leaves the bench just after edge F+1, so the next pixel lands on edge F+2.
    task automatic load_frame(input string tag);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk({tag, " busy@F"}, busy, 1);
        tick();
        chk({tag, " busy@F+1"}, busy, 0);
    endtask

    task automatic send_pixel(input string tag, input logic [WPX-1:0] x, input logic [WPY-1:0] y,
                              input logic [WCOLOR-1:0] ec, input logic [N_POLY-1:0] eh);
        pix_x     = x;
        pix_y     = y;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        chk({tag, " valid@T+1"}, color_valid, 0);
        tick();
        chk({tag, " valid@T+2"}, color_valid, 1);
        chk({tag, " color"}, color_out, ec);
        chk({tag, " hit"}, poly_hit, eh);
        tick();
        chk({tag, " valid@T+3"}, color_valid, 0);
        chk({tag, " color hold"}, color_out, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        frame_start    = 1'b0;
        pix_valid      = 1'b0;
        pix_x          = '0;
        pix_y          = '0;
        bg_color_in    = '0;
        poly_color_in  = '0;
        v0_x_in        = '0;
        v1_x_in        = '0;
        v2_x_in        = '0;
        v0_y_in        = '0;
        v1_y_in        = '0;
        v2_y_in        = '0;
        poly_enable_in = '0;
        tick();
        tick();
        chk("reset valid", color_valid, 0);
        chk("reset color", color_out, 0);
        chk("reset hit", poly_hit, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Reset default geometry: everything resolves to colour 0.
        send_pixel("rst px(0,0)", 0, 0, 6'h00, 4'b0000);
        send_pixel("rst px(5,7)", 5, 7, 6'h00, 4'b0000);

        // Basic fill and edge rule.
        bg_color_in = 6'h01;
        set_poly(0, 0, 0, 100, 0, 0, 100, 6'h30);
        poly_enable_in = 4'b0001;
        load_frame("basic");
        send_pixel("basic (10,10)", 10, 10, 6'h30, 4'b0001);
        send_pixel("basic (90,90)", 90, 90, 6'h01, 4'b0000);
        send_pixel("basic (50,50)", 50, 50, 6'h30, 4'b0001);
        send_pixel("basic (0,0)", 0, 0, 6'h30, 4'b0001);

        // Back-to-back pixels: one result per cycle.
        pix_valid = 1'b1;
        pix_x = 10; pix_y = 10;
        tick();
        pix_x = 90; pix_y = 90;
        tick();
        pix_x = 50; pix_y = 50;
        tick();
        pix_valid = 1'b0;
        chk("burst0 valid", color_valid, 1);
        chk("burst0 color", color_out, 6'h30);
        tick();
        chk("burst1 valid", color_valid, 1);
        chk("burst1 color", color_out, 6'h01);
        chk("burst1 hit", poly_hit, 4'b0000);
        tick();
        chk("burst2 valid", color_valid, 1);
        chk("burst2 color", color_out, 6'h30);
        tick();
        chk("burst end valid", color_valid, 0);

        // Opposite winding gives identical coverage.
        set_poly(0, 0, 0, 0, 100, 100, 0, 6'h30);
        load_frame("wind");
        send_pixel("wind (10,10)", 10, 10, 6'h30, 4'b0001);
        send_pixel("wind (90,90)", 90, 90, 6'h01, 4'b0000);
        send_pixel("wind (50,50)", 50, 50, 6'h30, 4'b0001);
        send_pixel("wind (0,0)", 0, 0, 6'h30, 4'b0001);

        // Priority.
        set_poly(0, 0, 0, 100, 0, 0, 100, 6'h0C);
        set_poly(1, 0, 0, 200, 0, 0, 200, 6'h03);
        poly_enable_in = 4'b0011;
        load_frame("prio");
        send_pixel("prio both", 20, 20, 6'h0C, 4'b0011);
        poly_enable_in = 4'b0010;
        load_frame("prio1");
        send_pixel("prio only1", 20, 20, 6'h03, 4'b0010);

        // Degenerate and disabled.
        set_poly(2, 0, 0, 50, 50, 100, 100, 6'h3F);
        set_poly(3, 0, 0, 200, 0, 0, 200, 6'h15);
        poly_enable_in = 4'b0100;
        load_frame("degen");
        send_pixel("degen/disabled", 50, 50, 6'h01, 4'b0000);
        poly_enable_in = 4'b1100;
        load_frame("p3on");
        send_pixel("p3 enabled", 50, 50, 6'h15, 4'b1000);

        // Inputs change without frame_start: shadow keeps the old frame.
        bg_color_in = 6'h2A;
        set_poly(3, 0, 0, 200, 0, 0, 200, 6'h0F);
        poly_enable_in = 4'b1111;
        send_pixel("shadow", 50, 50, 6'h15, 4'b1000);

        // Flush: two pixels in flight, pixels at F and F+1 dropped, F+2 accepted.
        pix_valid = 1'b1;
        pix_x = 250; pix_y = 10;
        tick();
        tick();
        frame_start = 1'b1;
        pix_x = 50; pix_y = 50;
        tick();
        frame_start = 1'b0;
        chk("flush valid@F", color_valid, 0);
        chk("flush color hold", color_out, 6'h15);
        chk("flush hit hold", poly_hit, 4'b1000);
        chk("flush busy@F", busy, 1);
        tick();
        chk("flush valid@F+1", color_valid, 0);
        chk("flush busy@F+1", busy, 0);
        tick();
        pix_valid = 1'b0;
        chk("flush valid@F+2", color_valid, 0);
        tick();
        chk("flush valid@F+3", color_valid, 0);
        tick();
        chk("newframe valid@F+4", color_valid, 1);
        chk("newframe color", color_out, 6'h0C);
        chk("newframe hit", poly_hit, 4'b1011);
        tick();

        // Back-to-back frame_start pulses extend busy.
        frame_start = 1'b1;
        tick();
        chk("b2b busy1", busy, 1);
        tick();
        frame_start = 1'b0;
        chk("b2b busy2", busy, 1);
        tick();
        chk("b2b busy end", busy, 0);
        send_pixel("b2b pixel", 50, 50, 6'h0C, 4'b1011);

        // Asynchronous reset mid-flight.
        pix_x = 10; pix_y = 10;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", color_valid, 0);
        chk("arst color", color_out, 0);
        chk("arst hit", poly_hit, 0);
        chk("arst busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("arst discard1", color_valid, 0);
        tick();
        chk("arst discard2", color_valid, 0);
        send_pixel("arst default", 50, 50, 6'h00, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/poly_raster.md
# poly_raster

Per-pixel triangle rasterizer directly downstream of the SPI frontend. Latches the frontend's background colour, polygon colours, vertices and enables into shadow registers at each frame start. It then evaluates every streamed pixel coordinate against all enabled triangles through a 3-stage pipeline. For each pixel it emits the colour of the highest-priority covering triangle, or the background colour, to the VGA output stage.

## Interface

Parameters (defaults match the widths in constants.v):
- WCOLOR, 6, colour width (RGB222)
- WPX, 10, pixel x width
- WPY, 9, pixel y width
- N_POLY, 4, number of triangles

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_start  in  1  one-cycle pulse; latch geometry, flush pipeline
- pix_valid  in  1  pix_x/pix_y carry a pixel this cycle
- pix_x  in  WPX  pixel column, unsigned
- pix_y  in  WPY  pixel row, unsigned
- bg_color_in  in  WCOLOR  background colour from frontend
- poly_color_in  in  WCOLOR*N_POLY  polygon colours, poly i at slice i
- v0_x_in, v1_x_in, v2_x_in  in  WPX*N_POLY  vertex x, packed the same way
- v0_y_in, v1_y_in, v2_y_in  in  WPY*N_POLY  vertex y
- poly_enable_in  in  N_POLY  per-polygon enable
- busy  out  1  geometry precompute in progress; pixels are dropped
- color_valid  out  1  color_out/poly_hit valid
- color_out  out  WCOLOR  resolved pixel colour
- poly_hit  out  N_POLY  per-polygon coverage of the emitted pixel

## Operation

- **Shadow registers.** On a clk edge with frame_start=1, all *_in geometry/colour/enable inputs are copied into shadow registers. Between pulses the inputs are ignored, so upstream may change them freely (no tearing).
- **Precompute cycle (cycle after latch).** Per polygon, register:
  - the edge vectors (v1-v0, v2-v1, v0-v2) as signed WPX+1 / WPY+1 values;
  - a `degenerate` flag, set when twice-area = (v1x-v0x)(v2y-v0y) - (v1y-v0y)(v2x-v0x) == 0.
- **Stage 1.** Register the pixel offsets p-v0, p-v1, p-v2 per polygon (signed, one bit wider than the coordinate).
- **Stage 2.** Register the three edge functions per polygon, E = ex*(py-ay) - ey*(px-ax), at full signed width (WPX+WPY+3 bits). No truncation.
- **Stage 3.** Resolve coverage and colour:
  - Polygon i hits iff enabled, not degenerate, and all three E >= 0 or all three E <= 0. The test is winding-independent and edge/vertex pixels count as inside.
  - poly_hit = hit vector.
  - color_out = colour of the lowest-index hit polygon (poly 0 on top), else shadow bg.
- **Flush.** frame_start clears all stage valid bits. Pixels in flight on that edge never produce color_valid.
- **Pixel dropping.** A pix_valid coinciding with frame_start or with busy=1 is dropped.
- **Reset.**
  - Shadow registers: colours, vertices, enables = 0.
  - Edge vectors = 0; degenerate flags = 1.
  - Stage valids = 0, busy = 0.
  - color_out = 0, poly_hit = 0, color_valid = 0.
  - After reset, with no frame_start, every accepted pixel returns color_out=0, poly_hit=0.

## Timing

- Throughput: one pixel per cycle, no backpressure.
- Latency: pixel accepted at edge T gives color_valid=1 in the cycle after edge T+2 (3 cycles).
- frame_start at edge F:
  - shadow loads at F;
  - busy=1 for the cycle after F;
  - edge vectors and degenerate flags load at F+1;
  - first accepted pixel is the one at edge F+2.
- Back-to-back frame_start pulses: each pulse re-latches and re-extends busy by one cycle.
- color_out and poly_hit hold their last value while color_valid=0.
- rst_n assertion mid-frame: all outputs go to reset values immediately (asynchronous), and in-flight pixels are discarded.

## Test plan

- **Reset default:** reset, then stream pixels (0,0) and (5,7) with no frame_start → color_valid 3 cycles later each, color_out=0, poly_hit=0.
- **Basic fill and edge rule:**
  - Setup: poly0 = (0,0),(100,0),(0,100), colour 6'h30, enable 4'b0001, bg 6'h01; frame_start.
  - Required: (10,10) → 6'h30, poly_hit 4'b0001; (90,90) → 6'h01; (50,50) (on hypotenuse) → 6'h30; (0,0) → 6'h30.
- **Winding:** same triangle entered as (0,0),(0,100),(100,0) → identical results to the previous scenario.
- **Priority:** poly0 and poly1 both cover (20,20), colours 6'h0C and 6'h03, enable 4'b0011 → color_out 6'h0C, poly_hit 4'b0011. With enable 4'b0010 → 6'h03.
- **Degenerate and disabled:**
  - Collinear poly2 (0,0),(50,50),(100,100), enabled → (50,50) returns bg, poly_hit bit2=0.
  - Poly3 covering the pixel with enable bit3=0 → no hit.
- **Shadowing and flush:**
  - Change inputs without frame_start → outputs unchanged.
  - Pulse frame_start with 2 pixels in flight → no color_valid for them.
  - Pixels at F and F+1 → dropped.
  - Pixel at F+2 → new colour at F+5.
